// File: rtl/remote_pkg.sv
// Shared types, constants and code-map helper for the remote answer encoder.
// Used by remote_answer_encoder.sv (optional macro REMOTE_LOCKOUT_EN lives there).
package remote_pkg;

    localparam logic [7:0] RM_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_REL
    } state_t;

    typedef enum logic [1:0] {
        PLAYER_NONE = 2'd0,
        PLAYER_P1   = 2'd1,
        PLAYER_P2   = 2'd2
    } player_t;

    // One-cold code: P1 choice1..4 pull bit7..bit4 low, P2 choice1..4 pull bit3..bit0 low
    function automatic logic [7:0] codeMap(input player_t player, input logic [3:0] buttons);
        logic [7:0] code;
        code = RM_IDLE;
        for (int i = 0; i < 4; i++) begin
            if (buttons[i]) begin
                if (player == PLAYER_P1) begin
                    code[7 - i] = 1'b0;
                end else if (player == PLAYER_P2) begin
                    code[3 - i] = 1'b0;
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output level only follows
// the synchronized input after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_count;

    // Counter tracks how many samples in a row disagree with the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_count <= '0;
            end else if (r_count == CNT_LAST) begin
                r_level <= r_sync2;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/remote_answer_encoder.sv
// Two-player answer buttons -> active-low remote code with fair tie-break.
// Optional macro REMOTE_LOCKOUT_EN: a player who transmitted is locked until new_problem.
module remote_answer_encoder
    import remote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_p1,
    input  logic [3:0] btn_p2,
    input  logic       enable,
    input  logic       new_problem,
    output logic [7:0] rm_out,
    output logic       tx_valid,
    output logic       busy
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        r_state;
    state_t        w_nextState;
    player_t       r_lastWinner;
    player_t       w_winner;
    logic [HW-1:0] r_holdCount;
    logic [7:0]    w_rawButtons;
    logic [7:0]    w_deb;
    logic [3:0]    w_deb1;
    logic [3:0]    w_deb2;
    logic [1:0]    w_lockEff;
    logic          w_cand1;
    logic          w_cand2;
    logic          w_winnerReleased;
    logic [7:0]    w_winCode;
    logic [7:0]    w_rmNext;
    logic          w_txNext;
    logic          w_sendDone;

    assign w_rawButtons = {btn_p2, btn_p1};

    for (genvar g = 0; g < 8; g++) begin : g_debounce
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_rawButtons[g]),
            .o_level(w_deb[g])
        );
    end

    assign w_deb1     = w_deb[3:0];
    assign w_deb2     = w_deb[7:4];
    assign w_sendDone = (r_state == SEND) && (r_holdCount == HOLD_LAST);

`ifdef REMOTE_LOCKOUT_EN
    logic [1:0] r_lock;

    // new_problem clears before candidates are evaluated; a finishing SEND re-locks its winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 2'b00;
        end else begin
            r_lock <= w_lockEff;
            if (w_sendDone) begin
                r_lock[(r_lastWinner == PLAYER_P1) ? 0 : 1] <= 1'b1;
            end
        end
    end

    assign w_lockEff = new_problem ? 2'b00 : r_lock;
`else
    logic w_unusedNewProblem;
    assign w_unusedNewProblem = new_problem;
    assign w_lockEff          = 2'b00;
`endif

    assign w_cand1 = $onehot(w_deb1) && !w_lockEff[0];
    assign w_cand2 = $onehot(w_deb2) && !w_lockEff[1];

    // On a tie the player who did not win last time gets the turn
    always_comb begin
        w_winner = PLAYER_P1;
        if (w_cand1 && w_cand2) begin
            w_winner = (r_lastWinner == PLAYER_P2) ? PLAYER_P1 : PLAYER_P2;
        end else if (w_cand2) begin
            w_winner = PLAYER_P2;
        end
    end

    assign w_winCode        = codeMap(w_winner, (w_winner == PLAYER_P1) ? w_deb1 : w_deb2);
    assign w_winnerReleased = (r_lastWinner == PLAYER_P1) ? (w_deb1 == 4'b0000) : (w_deb2 == 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_holdCount  <= '0;
            r_lastWinner <= PLAYER_P2;
            rm_out       <= RM_IDLE;
            tx_valid     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            rm_out      <= w_rmNext;
            tx_valid    <= w_txNext;
            r_holdCount <= (r_state == SEND && w_nextState == SEND) ? r_holdCount + 1'b1 : '0;
            if (r_state == IDLE && w_nextState == SEND) begin
                r_lastWinner <= w_winner;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (enable && (w_cand1 || w_cand2)) w_nextState = SEND;
            SEND:     if (w_sendDone) w_nextState = WAIT_REL;
            WAIT_REL: if (w_winnerReleased) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // The code is latched on entry to SEND and then recirculated from rm_out itself
    always_comb begin
        w_rmNext = RM_IDLE;
        w_txNext = 1'b0;
        if (w_nextState == SEND) begin
            w_txNext = 1'b1;
            w_rmNext = (r_state == IDLE) ? w_winCode : rm_out;
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_remote_answer_encoder.sv
// Scoreboard bench for remote_answer_encoder: a reference model predicts each
// transmission (code and start cycle), a monitor checks what the DUT drives.
module tb_remote_answer_encoder;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_p1;
    logic [3:0] btn_p2;
    logic       enable;
    logic       new_problem;
    logic [7:0] rm_out;
    logic       tx_valid;
    logic       busy;

    always #5 clk = ~clk;

    remote_answer_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_p1     (btn_p1),
        .btn_p2     (btn_p2),
        .enable     (enable),
        .new_problem(new_problem),
        .rm_out     (rm_out),
        .tx_valid   (tx_valid),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] code;
        int         startCycle;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference model state: raw input history, accepted levels, transaction bookkeeping
    logic [7:0] hist[6];
    logic [7:0] mDeb;
    bit         mInSeq;
    bit         mWasReset;
    int         mLastWin;
    int         mStart;
    bit   [1:0] mLock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [7:0] expectCode(input int player, input logic [3:0] b);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (b[i]) idx = i;
        if (player == 1) return 8'hFF ^ (8'h80 >> idx);
        return 8'hFF ^ (8'h08 >> idx);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 6; i++) hist[i] = 8'h00;
        mDeb     = 8'h00;
        mInSeq   = 1'b0;
        mLastWin = 2;
        mStart   = 0;
        mLock    = 2'b00;
    endtask

    task automatic modelStep();
        logic [3:0] d1, d2, wb;
        bit         c1, c2;
        bit   [1:0] lk;
        int         w;
        cyc++;
        mWasReset = rst;
        if (rst) begin
            modelReset();
            return;
        end
        d1 = mDeb[3:0];
        d2 = mDeb[7:4];
`ifdef REMOTE_LOCKOUT_EN
        lk = new_problem ? 2'b00 : mLock;
`else
        lk = 2'b00;
`endif
        c1 = ($countones(d1) == 1) && !lk[0];
        c2 = ($countones(d2) == 1) && !lk[1];
        if (!mInSeq) begin
            if (enable && (c1 || c2)) begin
                w  = (c1 && c2) ? ((mLastWin == 2) ? 1 : 2) : (c1 ? 1 : 2);
                wb = (w == 1) ? d1 : d2;
                expQ.push_back('{expectCode(w, wb), cyc});
                mInSeq   = 1'b1;
                mStart   = cyc;
                mLastWin = w;
            end
        end else if (cyc > mStart + HOLD && ((mLastWin == 1) ? d1 : d2) == 4'b0000) begin
            mInSeq = 1'b0;
        end
`ifdef REMOTE_LOCKOUT_EN
        if (mInSeq && cyc == mStart + HOLD) lk[mLastWin - 1] = 1'b1;
        mLock = lk;
`endif
        // A level is accepted once the input seen two edges ago has held its new value for DEB samples
        for (int i = 5; i > 0; i--) hist[i] = hist[i - 1];
        hist[0] = {btn_p2, btn_p1};
        for (int b = 0; b < 8; b++) begin
            if (hist[2][b] != mDeb[b] && hist[3][b] == hist[2][b] &&
                hist[4][b] == hist[2][b] && hist[5][b] == hist[2][b]) begin
                mDeb[b] = hist[2][b];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Monitor: pops an expectation whenever the DUT starts a transmission
    initial begin
        int         holdCnt;
        logic [7:0] held;
        exp_t       e;
        holdCnt = 0;
        held    = 8'hFF;
        forever begin
            @(negedge clk);
            if (mWasReset) begin
                checkOutput("reset_outputs", {22'd0, tx_valid, busy, rm_out}, {22'd0, 1'b0, 1'b0, 8'hFF});
                holdCnt = 0;
            end else begin
                checkOutput("busy", {31'd0, busy}, {31'd0, mInSeq});
                if (tx_valid) begin
                    if (holdCnt == 0) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected_tx", rm_out, 8'hFF);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("code", rm_out, e.code);
                            checkOutput("start_cycle", cyc, e.startCycle);
                        end
                        held = rm_out;
                    end else begin
                        checkOutput("hold_stable", rm_out, held);
                    end
                    holdCnt++;
                    if (holdCnt > HOLD) checkOutput("hold_too_long", holdCnt, HOLD);
                end else begin
                    if (holdCnt != 0) begin
                        checkOutput("hold_len", holdCnt, HOLD);
                        holdCnt = 0;
                    end
                    checkOutput("idle_code", rm_out, 8'hFF);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] p1, input logic [3:0] p2, input int cycles,
                                 input logic en, input logic np);
        btn_p1      = p1;
        btn_p2      = p2;
        enable      = en;
        new_problem = np;
        @(negedge clk);
        new_problem = 1'b0;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] randButtons();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return 4'(1 << $urandom_range(0, 3));
        if (r < 7) return 4'b0000;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        rst         = 1'b1;
        btn_p1      = 4'b0000;
        btn_p2      = 4'b0000;
        enable      = 1'b1;
        new_problem = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'b0001, 4'b0000, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b1000, 4'b0001, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b1000, 4'b0001, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0110, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b0000, 9, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0100, 10, 1'b1, 1'b0);
        pulseReset();
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 4, 1'b1, 1'b0);
        applyStimulus(4'b0100, 4'b1000, 16, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1000, 25, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 10, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 10, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 2, 1'b1, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 20, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 15, 1'b1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 24) == 0) pulseReset();
            applyStimulus(randButtons(), randButtons(), $urandom_range(1, 30),
                          ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
        end

        applyStimulus(4'b0000, 4'b0000, 40, 1'b1, 1'b0);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/remote_answer_encoder.md
REMOTE_ANSWER_ENCODER -- requirements
Module: remote_answer_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples before a button level is accepted.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles a valid code is driven on rm_out.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_p1  input  4  player-1 raw buttons, active-high, bit0=choice1 .. bit3=choice4, asynchronous.
REQ-006 btn_p2  input  4  player-2 raw buttons, same encoding.
REQ-007 enable  input  1  high = answers accepted; low = no new transmission starts.
REQ-008 new_problem  input  1  one-cycle pulse at problem change; used only with lockout compiled in.
REQ-009 rm_out  output  8  active-low remote code; idle 8'hFF.
REQ-010 tx_valid  output  1  high exactly while rm_out carries a code.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer then a debouncer; a debounced level changes only after DEBOUNCE_CYCLES identical synchronized samples.
REQ-013 Code map SHALL be one low bit: P1 choice1..4 -> bit7..bit4 (choice1 = 8'b0111_1111, choice4 = 8'b1110_1111); P2 choice1..4 -> bit3..bit0 (choice1 = 8'b1111_0111, choice4 = 8'b1111_1110).
REQ-014 A player's press SHALL be a candidate only if exactly one of that player's four debounced buttons is high; 0 or >=2 high = no candidate.
REQ-015 FSM states IDLE, SEND, WAIT_REL.
REQ-016 IDLE: rm_out=8'hFF, tx_valid=0; when enable=1 and a candidate exists, next cycle enters SEND with the winner's code registered.
REQ-017 Both players candidate in the same cycle: winner SHALL be the player who did not win the previous transmission; after reset P1 wins first.
REQ-018 SEND: rm_out=registered code, tx_valid=1 for exactly HOLD_CYCLES cycles, then WAIT_REL; code SHALL NOT change during SEND regardless of inputs or enable.
REQ-019 WAIT_REL: rm_out=8'hFF, tx_valid=0; return to IDLE when all four debounced buttons of the winning player are low.
REQ-020 Loser's buttons held across the winner's release SHALL be re-evaluated in IDLE and may transmit normally.
REQ-021 enable deasserting in SEND or WAIT_REL SHALL NOT abort the sequence.
REQ-022 rm_out and tx_valid SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-023 rst=1 at any clock edge: FSM->IDLE, rm_out=8'hFF, tx_valid=0, busy=0, synchronizers/debouncers cleared to released, last-winner = P2 (so P1 wins next tie), lockout flags cleared.
REQ-024 rst mid-SEND SHALL drop the code on the following edge; no partial hold resumes.

Configuration
REQ-025 Macro REMOTE_LOCKOUT_EN defined: a player who completes SEND SHALL be locked (never a candidate) until new_problem=1; new_problem clears both locks; new_problem coinciding with a press SHALL clear first, then evaluate.
REQ-026 Macro undefined: no lock state, new_problem ignored.

Structure
REQ-027 Shared package remote_pkg: RM_IDLE=8'hFF constant, state enum, player-id encoding (1=P1, 2=P2), code-map function.
REQ-028 One sub-module btn_debounce (synchronizer + counter, parameter DEBOUNCE_CYCLES), instantiated 8 times.

Verification
REQ-029 btn_p1=4'b0001 held 20 cycles, enable=1 -> rm_out=8'b0111_1111, tx_valid=1 for 8 cycles, starting 2+4+1 cycles after press, then 8'hFF.
REQ-030 btn_p1=4'b1000 and btn_p2=4'b0001 same edge after reset -> P1 code 8'b1110_1111; repeat after release -> P2 code 8'b1111_0111.
REQ-031 btn_p2=4'b0110 -> no code, tx_valid stays 0.
REQ-032 Button glitch 3 cycles wide -> no code; release before HOLD_CYCLES end -> full 8-cycle hold still driven.
REQ-033 rst pulse on 4th SEND cycle -> rm_out=8'hFF next cycle, busy=0.
REQ-034 REMOTE_LOCKOUT_EN: P1 sends, releases, presses again -> no code; new_problem pulse then press -> code sent.
